slc3_input_conditioner: RTL and testbench
=========================================

# slc3_input_conditioner

Front-end conditioner that sits between the board's raw push-buttons and switches and the SLC-3 top level. It synchronizes the active-low Run and Continue buttons into the Clk domain and debounces them. It also produces one-cycle press strobes and a two-flop-synchronized copy of the 10 slide switches. The debounced levels keep the buttons' active-low polarity, so they drive the top level's Run and Continue inputs directly.

## Interface

Parameters:
- DB_CYCLES, default 500000: consecutive stable synchronized cycles required before a debounced level changes. Must be ≥ 1. Simulation benches override it to 4.
- CNT_W, default $clog2(DB_CYCLES+1): width of each debounce counter.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Run_raw  in  1  raw Run button, active-low (0 = pressed), asynchronous.
- Continue_raw  in  1  raw Continue button, active-low, asynchronous.
- SW_raw  in  10  raw slide switches, asynchronous.
- Run_db  out  1  debounced Run level, active-low.
- Continue_db  out  1  debounced Continue level, active-low.
- Run_press  out  1  one-cycle high strobe on Run_db 1→0.
- Continue_press  out  1  one-cycle high strobe on Continue_db 1→0.
- SW_sync  out  10  SW_raw after a two-flop synchronizer.

## Operation

- Run and Continue each use an identical, independent channel: sync1 → sync2 → debounce counter → db register → press strobe.
- Synchronizer: sync1 <= raw, sync2 <= sync1.
- Debounce counter, evaluated each cycle:
  - If sync2 == db, cnt <= 0.
  - Otherwise, if cnt == DB_CYCLES-1, then db <= sync2 and cnt <= 0.
  - Otherwise, cnt <= cnt+1.
- Result: db changes only after sync2 has disagreed with db for DB_CYCLES consecutive cycles. Any agreeing cycle restarts the count.
- Press strobe:
  - press is registered and goes high in the same cycle db transitions 1→0.
  - press is low at every other time.
  - Releases (db 0→1) produce no strobe.
- Switches: SW_sync <= sync1_sw <= SW_raw. The switches are not debounced.
- Effective channel states are IDLE (db=1, cnt=0), ARMING_PRESS (db=1, cnt>0), HELD (db=0, cnt=0) and ARMING_RELEASE (db=0, cnt>0). Transitions follow the counter rule above.

## Timing

- Reset (Reset=0 at a rising edge) sets:
  - sync1, sync2 and db to 1 on both channels;
  - cnt to 0;
  - Run_press and Continue_press to 0;
  - SW_sync and its first stage to 0.
- Reset has priority over all other updates.
- Latency: raw level first sampled at edge E0 → sync2 reflects it after E1 → db changes after edge E1+DB_CYCLES. That is DB_CYCLES+2 edges in total, 6 edges with DB_CYCLES=4.
  - press is high for exactly the one cycle following that edge.
- SW latency: 2 edges.
- Glitch rejection: a raw pulse whose synchronized width is shorter than DB_CYCLES cycles never changes db.
- Simultaneous events: the two channels never interact. Both may strobe in the same cycle.
- Reset mid-count: cnt is cleared and the channel returns to IDLE.
  - A button still held after reset release is treated as a new press. It strobes DB_CYCLES+2 edges after the first post-reset edge.
- The counter never exceeds DB_CYCLES-1, so it never wraps.
- DB_CYCLES=1 gives a pure synchronizer with 3-edge latency.

## Test plan

All scenarios use DB_CYCLES=4.

1. Reset held 3 cycles with raw inputs at 1 and SW_raw=10'h3FF → Run_db=Continue_db=1, both press=0, SW_sync=0. After release, SW_sync=10'h3FF 2 edges later.
2. Clean press: Run_raw=0 for 12 cycles, then 1 → Run_db falls 6 edges after first low sample, Run_press is high for exactly 1 cycle, and Run_db rises 6 edges after Run_raw returns high with no strobe. Continue_db stays at 1 throughout.
3. Bounce: Run_raw pattern 0,0,0,1,0,0,0,1,0,0 (one cycle each), then steady 1 → Run_db stays 1 and Run_press never asserts.
4. Simultaneous: Run_raw and Continue_raw both driven 0 on the same edge and held 8 cycles → Run_press and Continue_press are high in the same single cycle, 6 edges after the first low sample.
5. Reset mid-operation: Run_raw=0, Reset asserted on the 4th cycle for 1 cycle, Run_raw kept low → no strobe before reset. Run_press fires 6 edges after the first post-reset edge.
6. Switch sync: SW_raw stepped 10'h000 → 10'h2A5 → 10'h15A on consecutive cycles → SW_sync shows the same sequence delayed by exactly 2 edges.

Source files
------------

// File: rtl/slc3_input_conditioner.sv
// Input conditioner for the SLC-3 board: synchronizes and debounces the
// active-low Run/Continue buttons, emits press strobes, and synchronizes the switches.

module slc3_db_channel #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic db,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // The count only survives while sync2 keeps disagreeing with db, so a
  // single agreeing cycle throws away any partial progress toward a change.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      db    <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        db    <= sync2;
        cnt   <= '0;
        press <= db & ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

module slc3_input_conditioner #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run_raw,
  input  logic       Continue_raw,
  input  logic [9:0] SW_raw,
  output logic       Run_db,
  output logic       Continue_db,
  output logic       Run_press,
  output logic       Continue_press,
  output logic [9:0] SW_sync
);

  logic [9:0] sw_sync1;

  slc3_db_channel #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_run (
    .clk     (Clk),
    .reset_n (Reset),
    .raw     (Run_raw),
    .db      (Run_db),
    .press   (Run_press)
  );

  slc3_db_channel #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_continue (
    .clk     (Clk),
    .reset_n (Reset),
    .raw     (Continue_raw),
    .db      (Continue_db),
    .press   (Continue_press)
  );

  // Switches are static settings, so a plain two-flop synchronizer suffices.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sw_sync1 <= '0;
      SW_sync  <= '0;
    end else begin
      sw_sync1 <= SW_raw;
      SW_sync  <= sw_sync1;
    end
  end

endmodule

// File: tb/tb_slc3_input_conditioner.sv
// Bench for slc3_input_conditioner: window-based behavioural model checked
// every cycle, plus directed scenarios with hand-computed latencies.

module tb_slc3_input_conditioner;

  localparam int DB = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Run_raw = 1'b1;
  logic       Continue_raw = 1'b1;
  logic [9:0] SW_raw = 10'h3FF;
  logic       Run_db, Continue_db, Run_press, Continue_press;
  logic [9:0] SW_sync;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  slc3_input_conditioner #(.DB_CYCLES(DB)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Run_raw        (Run_raw),
    .Continue_raw   (Continue_raw),
    .SW_raw         (SW_raw),
    .Run_db         (Run_db),
    .Continue_db    (Continue_db),
    .Run_press      (Run_press),
    .Continue_press (Continue_press),
    .SW_sync        (SW_sync)
  );

  always #5 Clk = ~Clk;

  // Model: each button's debounced level flips once the last DB synchronized
  // samples all disagree with it; the synchronizer is a pure two-sample delay.
  logic       mS1 [2];
  logic       mS2 [2];
  logic       mDb [2];
  logic       mPress [2];
  logic       hist [2][DB];
  int         fill [2];
  logic [9:0] mSw1, mSwSync;

  always @(posedge Clk) begin
    logic raw [2];
    bit   flip;
    raw[0] = Run_raw;
    raw[1] = Continue_raw;
    if (!Reset) begin
      for (int c = 0; c < 2; c++) begin
        mS1[c] = 1'b1; mS2[c] = 1'b1; mDb[c] = 1'b1; mPress[c] = 1'b0; fill[c] = 0;
      end
      mSw1 = '0;
      mSwSync = '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < DB - 1; k++) hist[c][k] = hist[c][k+1];
        hist[c][DB-1] = mS2[c];
        if (fill[c] < DB) fill[c] = fill[c] + 1;
        flip = (fill[c] == DB);
        for (int k = 0; k < DB; k++) if (hist[c][k] == mDb[c]) flip = 1'b0;
        mPress[c] = flip && mDb[c];
        if (flip) mDb[c] = ~mDb[c];
        mS2[c] = mS1[c];
        mS1[c] = raw[c];
      end
      mSwSync = mSw1;
      mSw1 = SW_raw;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (checkEn) begin
      checkOutput("model Run_db", 32'(Run_db), 32'(mDb[0]));
      checkOutput("model Continue_db", 32'(Continue_db), 32'(mDb[1]));
      checkOutput("model Run_press", 32'(Run_press), 32'(mPress[0]));
      checkOutput("model Continue_press", 32'(Continue_press), 32'(mPress[1]));
      checkOutput("model SW_sync", 32'(SW_sync), 32'(mSwSync));
    end
  end

  task automatic applyStimulus(input logic rst, input logic run, input logic cont, input logic [9:0] sw);
    @(negedge Clk);
    Reset = rst;
    Run_raw = run;
    Continue_raw = cont;
    SW_raw = sw;
  endtask

  task automatic stepEdges(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  // Counts rising edges (sampled at the following negedge) until a condition holds.
  // sel: 0 = Run_press, 1 = Continue_press, 2 = Run_db high, 3 = both presses.
  task automatic countUntil(input int sel, output int n);
    bit hit;
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      case (sel)
        0:       hit = Run_press;
        1:       hit = Continue_press;
        2:       hit = Run_db;
        default: hit = Run_press && Continue_press;
      endcase
      if (hit) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    bit sawBad;
    logic [9:0] swSeen [4];

    // Reset held with buttons released and all switches up.
    @(posedge Clk);
    @(negedge Clk);
    checkEn = 1'b1;
    stepEdges(2);
    checkOutput("reset Run_db", 32'(Run_db), 32'd1);
    checkOutput("reset Continue_db", 32'(Continue_db), 32'd1);
    checkOutput("reset Run_press", 32'(Run_press), 32'd0);
    checkOutput("reset SW_sync", 32'(SW_sync), 32'h0);
    Reset = 1'b1;
    stepEdges(1);
    checkOutput("SW after 1 edge", 32'(SW_sync), 32'h0);
    stepEdges(1);
    checkOutput("SW after 2 edges", 32'(SW_sync), 32'h3FF);

    // Clean Run press and release.
    applyStimulus(1'b1, 1'b0, 1'b1, 10'h3FF);
    countUntil(0, n);
    checkOutput("Run press latency", 32'(n), 32'd6);
    stepEdges(1);
    checkOutput("Run press one cycle", 32'(Run_press), 32'd0);
    checkOutput("Run_db held low", 32'(Run_db), 32'd0);
    stepEdges(5);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'h3FF);
    countUntil(2, n);
    checkOutput("Run release latency", 32'(n), 32'd6);
    checkOutput("Continue_db untouched", 32'(Continue_db), 32'd1);

    // Bounce pattern never reaches DB consecutive low samples.
    begin
      logic [9:0] pat;
      pat = 10'b0001000100;
      sawBad = 1'b0;
      for (int i = 0; i < 10; i++) begin
        applyStimulus(1'b1, pat[9-i], 1'b1, 10'h3FF);
        if (Run_press || !Run_db) sawBad = 1'b1;
      end
      Run_raw = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge Clk);
        if (Run_press || !Run_db) sawBad = 1'b1;
      end
      checkOutput("bounce rejected", 32'(sawBad), 32'd0);
    end

    // Both buttons pressed on the same edge.
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h3FF);
    countUntil(3, n);
    checkOutput("simultaneous press latency", 32'(n), 32'd6);
    stepEdges(2);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'h3FF);
    stepEdges(10);

    // Reset pulse in the middle of a press attempt.
    applyStimulus(1'b1, 1'b0, 1'b1, 10'h3FF);
    sawBad = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      if (Run_press) sawBad = 1'b1;
    end
    Reset = 1'b0;
    @(negedge Clk);
    if (Run_press) sawBad = 1'b1;
    checkOutput("no press before reset", 32'(sawBad), 32'd0);
    Reset = 1'b1;
    countUntil(0, n);
    checkOutput("post-reset press latency", 32'(n), 32'd6);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'h3FF);
    stepEdges(10);

    // Switch stepping: output trails input by two edges.
    applyStimulus(1'b1, 1'b1, 1'b1, 10'h000);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'h2A5);
    swSeen[0] = SW_sync;
    applyStimulus(1'b1, 1'b1, 1'b1, 10'h15A);
    swSeen[1] = SW_sync;
    @(negedge Clk);
    swSeen[2] = SW_sync;
    @(negedge Clk);
    swSeen[3] = SW_sync;
    checkOutput("SW step 0", 32'(swSeen[0]), 32'h3FF);
    checkOutput("SW step 1", 32'(swSeen[1]), 32'h000);
    checkOutput("SW step 2", 32'(swSeen[2]), 32'h2A5);
    checkOutput("SW step 3", 32'(swSeen[3]), 32'h15A);

    stepEdges(3);
    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
